// File: rtl/shadow_dump_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_dump_unpacker
//  Description : Consumes the serial dump of a shadow capture chain. It drives
//                the chain's dump enable and samples one serial bit per
//                enabled clock. Bits are packed MSB-first into WORD_WIDTH-bit
//                words, which are queued in a small registered FIFO. The FIFO
//                is read out through a valid/ready stream.
//  Ports       : clk, rst (sync, active-high)
//                dump_req  - 1-cycle start pulse, ignored while busy
//                d_en      - dump enable to the chain (combinational)
//                s_bit     - serial bit from the chain
//                out_data / out_valid / out_ready / out_last - FIFO head stream
//                out_parity- XOR of out_data (SHADOW_UNPACK_PARITY_EN only)
//                busy      - dump in progress
//  Options     : `define SHADOW_UNPACK_PARITY_EN adds out_parity and a
//                per-entry parity bit in the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_dump_unpacker #(
    parameter int CHAIN_LEN   = 64,
    parameter int WORD_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dump_req,
    output logic                  d_en,
    input  logic                  s_bit,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
`ifdef SHADOW_UNPACK_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  busy
);

    localparam int c_REM   = CHAIN_LEN % WORD_WIDTH;
    localparam int c_POS_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_POS_W-1:0]     c_TOP_POS  = c_POS_W'(WORD_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] c_LAST_CNT = COUNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [c_PTR_W-1:0]     c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_OCC_W-1:0]     c_FULL_OCC = c_OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Sample counter, bit position inside the word being assembled, and the
    // partially assembled word (unfilled bits stay 0).
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [c_POS_W-1:0]     r_pos;
    logic [WORD_WIDTH-1:0]  r_word;
    logic [WORD_WIDTH-1:0]  w_word_ins;

    // FIFO storage
    logic [WORD_WIDTH-1:0]  r_mem   [FIFO_DEPTH];
    logic                   r_lastq [FIFO_DEPTH];
`ifdef SHADOW_UNPACK_PARITY_EN
    logic                   r_par   [FIFO_DEPTH];
`endif
    logic [c_PTR_W-1:0]     r_wr;
    logic [c_PTR_W-1:0]     r_rd;
    logic [c_OCC_W-1:0]     r_occ;

    logic                   w_full;
    logic                   w_word_done;
    logic                   w_stall;
    logic                   w_push;
    logic [WORD_WIDTH-1:0]  w_push_data;
    logic                   w_push_last;
    logic                   w_pop;

    assign w_full      = (r_occ == c_FULL_OCC);
    assign w_word_done = (r_pos == '0);
    // The full flag is registered, so a pop in this cycle does not lift the
    // stall until the next one.
    assign w_stall     = w_full & w_word_done;

    // Current word with this cycle's serial bit dropped into place.
    always_comb begin
        w_word_ins        = r_word;
        w_word_ins[r_pos] = s_bit;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, chain enable and FIFO push decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        d_en        = 1'b0;
        w_push      = 1'b0;
        w_push_data = w_word_ins;
        w_push_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_req) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                d_en = ~w_stall & ~rst;
                if (d_en && w_word_done) begin
                    w_push      = 1'b1;
                    // Only true when the chain length is a whole number of
                    // words; otherwise the last word is pushed in FLUSH.
                    w_push_last = (r_cnt == c_LAST_CNT);
                end
                if (d_en && (r_cnt == c_LAST_CNT)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (c_REM != 0) begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_data = r_word;
                        w_push_last = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sample counter and word assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pos  <= c_TOP_POS;
            r_word <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt  <= '0;
            r_pos  <= c_TOP_POS;
            r_word <= '0;
        end else if (d_en) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_word_done) begin
                r_pos  <= c_TOP_POS;
                r_word <= '0;
            end else begin
                r_pos  <= r_pos - 1'b1;
                r_word <= w_word_ins;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign w_pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]   <= '0;
                r_lastq[i] <= 1'b0;
`ifdef SHADOW_UNPACK_PARITY_EN
                r_par[i]   <= 1'b0;
`endif
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr]   <= w_push_data;
                r_lastq[r_wr] <= w_push_last;
`ifdef SHADOW_UNPACK_PARITY_EN
                r_par[r_wr]   <= ^w_push_data;
`endif
                r_wr <= (r_wr == c_LAST_PTR) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_LAST_PTR) ? '0 : r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // Outputs are forced low while rst is asserted, including the reset cycle.
    assign out_valid  = (r_occ != '0) & ~rst;
    assign out_data   = rst ? '0 : r_mem[r_rd];
    assign out_last   = out_valid & r_lastq[r_rd];
`ifdef SHADOW_UNPACK_PARITY_EN
    assign out_parity = ~rst & r_par[r_rd];
`endif
    assign busy       = (r_state != S_IDLE) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_shadow_dump_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shadow_dump_unpacker
//  Description : Directed self-checking bench. Three unpacker instances cover
//                64-bit, 40-bit (partial last word) and 96-bit/depth-1 chains.
//                Each instance has a simple shadow chain model that presents
//                bit CHAIN_LEN-1-k on sample k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shadow_dump_unpacker;

    logic clk;
    logic rst;

    // Instance A: 64-bit chain, 4-deep FIFO
    logic        dump_req_a, d_en_a, s_bit_a, out_valid_a, out_ready_a, out_last_a, busy_a;
    logic [31:0] out_data_a;
    logic [63:0] chain_a;
    int          idx_a, den_a;
    logic [31:0] wq_a[$];
    logic        lq_a[$];

    // Instance B: 40-bit chain
    logic        dump_req_b, d_en_b, s_bit_b, out_valid_b, out_ready_b, out_last_b, busy_b;
    logic [31:0] out_data_b;
    logic [39:0] chain_b;
    int          idx_b, den_b;
    logic [31:0] wq_b[$];
    logic        lq_b[$];

    // Instance C: 96-bit chain, 1-deep FIFO
    logic        dump_req_c, d_en_c, s_bit_c, out_valid_c, out_ready_c, out_last_c, busy_c;
    logic [31:0] out_data_c;
    logic [95:0] chain_c;
    int          idx_c, den_c;
    logic [31:0] wq_c[$];
    logic        lq_c[$];

`ifdef SHADOW_UNPACK_PARITY_EN
    logic par_a, par_b, par_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    shadow_dump_unpacker #(.CHAIN_LEN(64), .WORD_WIDTH(32), .FIFO_DEPTH(4), .COUNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .dump_req(dump_req_a), .d_en(d_en_a), .s_bit(s_bit_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a),
`ifdef SHADOW_UNPACK_PARITY_EN
        .out_parity(par_a),
`endif
        .busy(busy_a)
    );

    shadow_dump_unpacker #(.CHAIN_LEN(40), .WORD_WIDTH(32), .FIFO_DEPTH(4), .COUNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .dump_req(dump_req_b), .d_en(d_en_b), .s_bit(s_bit_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b),
`ifdef SHADOW_UNPACK_PARITY_EN
        .out_parity(par_b),
`endif
        .busy(busy_b)
    );

    shadow_dump_unpacker #(.CHAIN_LEN(96), .WORD_WIDTH(32), .FIFO_DEPTH(1), .COUNT_WIDTH(16)) u_c (
        .clk(clk), .rst(rst), .dump_req(dump_req_c), .d_en(d_en_c), .s_bit(s_bit_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_last(out_last_c),
`ifdef SHADOW_UNPACK_PARITY_EN
        .out_parity(par_c),
`endif
        .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow chain models: restart at an accepted dump_req, advance per enable.
    assign s_bit_a = (idx_a < 64) ? chain_a[63 - idx_a] : 1'b0;
    assign s_bit_b = (idx_b < 40) ? chain_b[39 - idx_b] : 1'b0;
    assign s_bit_c = (idx_c < 96) ? chain_c[95 - idx_c] : 1'b0;

    initial begin
        idx_a = 0; idx_b = 0; idx_c = 0;
        den_a = 0; den_b = 0; den_c = 0;
    end

    always @(posedge clk) begin
        if (rst || (dump_req_a && !busy_a)) idx_a <= 0;
        else if (d_en_a)                    idx_a <= idx_a + 1;
        if (rst || (dump_req_b && !busy_b)) idx_b <= 0;
        else if (d_en_b)                    idx_b <= idx_b + 1;
        if (rst || (dump_req_c && !busy_c)) idx_c <= 0;
        else if (d_en_c)                    idx_c <= idx_c + 1;
        if (d_en_a) den_a <= den_a + 1;
        if (d_en_b) den_b <= den_b + 1;
        if (d_en_c) den_c <= den_c + 1;
        if (out_valid_a && out_ready_a) begin wq_a.push_back(out_data_a); lq_a.push_back(out_last_a); end
        if (out_valid_b && out_ready_b) begin wq_b.push_back(out_data_b); lq_b.push_back(out_last_b); end
        if (out_valid_c && out_ready_c) begin wq_c.push_back(out_data_c); lq_c.push_back(out_last_c); end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_a();
        dump_req_a = 1'b1;
        @(negedge clk);
        dump_req_a = 1'b0;
        check("a_den_start", d_en_a, 1);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 300 && busy_a; i++) @(negedge clk);
        check("a_idle", busy_a, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int base;
        int d0;

        rst = 1'b1;
        dump_req_a = 0; dump_req_b = 0; dump_req_c = 0;
        out_ready_a = 1; out_ready_b = 1; out_ready_c = 0;
        chain_a = '0; chain_b = '0; chain_c = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_den", d_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {out_valid_a, out_valid_b, out_valid_c}, 0);
        check("post_rst_last", {out_last_a, out_last_b, out_last_c}, 0);
        check("post_rst_busy", {busy_a, busy_b, busy_c}, 0);

        // ---------------- 1: 64-bit dump, latency ----------------
        chain_a = 64'hDEADBEEF01234567;
        base = wq_a.size();
        d0 = den_a;
        start_a();
        n = 0;
        while (!out_valid_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", n, 32);
        wait_idle_a();
        check("t1_den", den_a - d0, 64);
        check("t1_nwords", wq_a.size() - base, 2);
        if (wq_a.size() >= base + 2) begin
            check("t1_w0", wq_a[base], 32'hDEADBEEF);
            check("t1_l0", lq_a[base], 0);
            check("t1_w1", wq_a[base+1], 32'h01234567);
            check("t1_l1", lq_a[base+1], 1);
        end

        // ---------------- 4: dump_req while busy ----------------
        chain_a = 64'h0123456789ABCDEF;
        base = wq_a.size();
        d0 = den_a;
        start_a();
        repeat (5) @(negedge clk);
        dump_req_a = 1'b1;
        @(negedge clk);
        dump_req_a = 1'b0;
        wait_idle_a();
        repeat (5) @(negedge clk);
        check("t4_den", den_a - d0, 64);
        check("t4_nwords", wq_a.size() - base, 2);
        if (wq_a.size() >= base + 2) begin
            check("t4_w0", wq_a[base], 32'h01234567);
            check("t4_w1", wq_a[base+1], 32'h89ABCDEF);
            check("t4_lasts", {lq_a[base], lq_a[base+1]}, 2'b01);
        end

        // ---------------- 2: 40-bit chain, partial last word ----------------
        chain_b = 40'hDEADBEEFA5;
        base = wq_b.size();
        d0 = den_b;
        dump_req_b = 1'b1;
        @(negedge clk);
        dump_req_b = 1'b0;
        for (int i = 0; i < 300 && busy_b; i++) @(negedge clk);
        check("t2_idle", busy_b, 0);
        repeat (3) @(negedge clk);
        check("t2_den", den_b - d0, 40);
        check("t2_nwords", wq_b.size() - base, 2);
        if (wq_b.size() >= base + 2) begin
            check("t2_w0", wq_b[base], 32'hDEADBEEF);
            check("t2_w1", wq_b[base+1], 32'hA5000000);
            check("t2_lasts", {lq_b[base], lq_b[base+1]}, 2'b01);
        end

        // ---------------- 3: 96-bit chain, depth-1 FIFO back-pressure ----------------
        chain_c = 96'h0123456789ABCDEFFEDCBA98;
        base = wq_c.size();
        d0 = den_c;
        dump_req_c = 1'b1;
        @(negedge clk);
        dump_req_c = 1'b0;
        repeat (80) @(negedge clk);
        check("t3_den_stall1", den_c - d0, 63);
        check("t3_den_low", d_en_c, 0);
        check("t3_head0", out_data_c, 32'h01234567);
        out_ready_c = 1'b1;
        @(negedge clk);
        out_ready_c = 1'b0;
        check("t3_resume1", d_en_c, 1);
        repeat (40) @(negedge clk);
        check("t3_den_stall2", den_c - d0, 95);
        check("t3_head1", out_data_c, 32'h89ABCDEF);
        out_ready_c = 1'b1;
        @(negedge clk);
        out_ready_c = 1'b0;
        check("t3_resume2", d_en_c, 1);
        for (int i = 0; i < 300 && busy_c; i++) @(negedge clk);
        check("t3_idle", busy_c, 0);
        out_ready_c = 1'b1;
        repeat (4) @(negedge clk);
        out_ready_c = 1'b0;
        check("t3_den", den_c - d0, 96);
        check("t3_nwords", wq_c.size() - base, 3);
        if (wq_c.size() >= base + 3) begin
            check("t3_w2", wq_c[base+2], 32'hFEDCBA98);
            check("t3_lasts", {lq_c[base], lq_c[base+1], lq_c[base+2]}, 3'b001);
        end

        // ---------------- 5: reset mid-dump ----------------
        chain_a = 64'hCAFEBABE12345678;
        start_a();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_den", d_en_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_valid", out_valid_a, 0);
        chain_a = 64'h1122334455667788;
        base = wq_a.size();
        d0 = den_a;
        start_a();
        wait_idle_a();
        check("t5_den_total", den_a - d0, 64);
        check("t5_nwords", wq_a.size() - base, 2);
        if (wq_a.size() >= base + 2) begin
            check("t5_w0", wq_a[base], 32'h11223344);
            check("t5_w1", wq_a[base+1], 32'h55667788);
        end

        // ---------------- 6: words held in FIFO, parity ----------------
        out_ready_a = 1'b0;
        chain_a = 64'hDEADBEEF00000001;
        start_a();
        wait_idle_a();
        check("t6_head0", out_data_a, 32'hDEADBEEF);
        check("t6_last0", out_last_a, 0);
`ifdef SHADOW_UNPACK_PARITY_EN
        check("t6_par0", par_a, 0);
`endif
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        check("t6_head1", out_data_a, 32'h00000001);
        check("t6_last1", out_last_a, 1);
`ifdef SHADOW_UNPACK_PARITY_EN
        check("t6_par1", par_a, 1);
`endif
        out_ready_a = 1'b1;
        @(negedge clk);
        check("t6_empty", out_valid_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
